// File: rtl/mem_stage.sv
// Memory stage: issues load/store on a req/gnt/rvalid bus, aligns and extends load data, registers MEM/WB.
// Latency: non-memory ops 1 cycle; memory ops at least 2 cycles (gnt with req, rvalid next cycle).
// Backpressure: busy_o holds upstream stable from request until rvalid (or timeout); MEM/WB gets bubbles meanwhile.
//
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   stallM_i                      incoming slot is a bubble
//   pcM_i, instrM_i, operationM_i instruction context from EX/MEM
//   rdM_port_i                    destination {addr, valid, data} from execute
//   memM_wrt_ena_i, memM_addr_i, memM_sdata_i   store enable, effective address, store data
//   dmem_*                        data memory bus (req/we/be/addr/wdata out, gnt/rvalid/rdata in)
//   busy_o                        stall request to fetch/decode/execute
//   pcM_o, instrM_o, operationM_o, rdM_port_o   MEM/WB register
//   misaligned_o                  one-cycle pulse alongside a dropped misaligned access
//   bus_timeout_o                 sticky bus timeout flag

package riscv_pkg;
  parameter int XLEN = 32;

  typedef enum logic [5:0] {
    UNKNOWN = 6'd0,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA
  } operation_e;

  typedef struct packed {
    logic [4:0]      addr;
    logic            valid;
    logic [XLEN-1:0] data;
  } rd_port_t;
endpackage

module mem_stage
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             stallM_i,
  input  logic [XLEN-1:0]  pcM_i,
  input  logic [XLEN-1:0]  instrM_i,
  input  operation_e       operationM_i,
  input  rd_port_t         rdM_port_i,
  input  logic             memM_wrt_ena_i,
  input  logic [XLEN-1:0]  memM_addr_i,
  input  logic [XLEN-1:0]  memM_sdata_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [3:0]       dmem_be_o,
  output logic [XLEN-1:0]  dmem_addr_o,
  output logic [XLEN-1:0]  dmem_wdata_o,
  input  logic             dmem_gnt_i,
  input  logic             dmem_rvalid_i,
  input  logic [XLEN-1:0]  dmem_rdata_i,
  output logic             busy_o,
  output logic [XLEN-1:0]  pcM_o,
  output logic [XLEN-1:0]  instrM_o,
  output operation_e       operationM_o,
  output rd_port_t         rdM_port_o,
  output logic             misaligned_o,
  output logic             bus_timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q;

  logic            is_load, is_store;
  logic            size_b, size_h, size_w, sign_ext;
  logic            mem_op, misaligned, start;
  logic [1:0]      boff;
  logic [3:0]      be_raw;
  logic [XLEN-1:0] wdata_raw;
  logic [XLEN-1:0] rshift;
  logic [XLEN-1:0] load_data;

  logic            req, busy, complete, timeout_hit;
  logic            wb_valid;
  logic [XLEN-1:0] wb_data;

  // ---------------------------------------------------------------- decode
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_b   = 1'b0;
    size_h   = 1'b0;
    size_w   = 1'b0;
    sign_ext = 1'b0;
    case (operationM_i)
      LB:      begin is_load = 1'b1; size_b = 1'b1; sign_ext = 1'b1; end
      LH:      begin is_load = 1'b1; size_h = 1'b1; sign_ext = 1'b1; end
      LW:      begin is_load = 1'b1; size_w = 1'b1; end
      LBU:     begin is_load = 1'b1; size_b = 1'b1; end
      LHU:     begin is_load = 1'b1; size_h = 1'b1; end
      SB:      begin is_store = memM_wrt_ena_i; size_b = 1'b1; end
      SH:      begin is_store = memM_wrt_ena_i; size_h = 1'b1; end
      SW:      begin is_store = memM_wrt_ena_i; size_w = 1'b1; end
      default: ;
    endcase
  end

  assign boff       = memM_addr_i[1:0];
  assign mem_op     = (is_load | is_store) & ~stallM_i;
  assign misaligned = mem_op & ((size_h & boff[0]) | (size_w & (|boff)));
  assign start      = mem_op & ~misaligned;

  // ---------------------------------------------------------------- bus lanes
  always_comb begin
    if (size_w)      be_raw = 4'b1111;
    else if (size_h) be_raw = 4'b0011 << boff;
    else             be_raw = 4'b0001 << boff;
  end

  // Lane replication lets the memory pick the written bytes using be alone.
  always_comb begin
    if (size_w)      wdata_raw = memM_sdata_i;
    else if (size_h) wdata_raw = {2{memM_sdata_i[15:0]}};
    else             wdata_raw = {4{memM_sdata_i[7:0]}};
  end

  assign rshift = dmem_rdata_i >> {boff, 3'b000};

  always_comb begin
    if (size_w)
      load_data = rshift;
    else if (size_h)
      load_data = {{(XLEN-16){sign_ext & rshift[15]}}, rshift[15:0]};
    else
      load_data = {{(XLEN-8){sign_ext & rshift[7]}}, rshift[7:0]};
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) wait_cnt_q <= '0;
      else                 wait_cnt_q <= wait_cnt_q + CW'(1);
    end
  end

  // Timeout wins over a late gnt in REQ; a real rvalid in WAIT wins over timeout.
  // An rvalid arriving while still in REQ is not a response to this request.
  always_comb begin
    state_d     = state_q;
    req         = 1'b0;
    busy        = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          req     = 1'b1;
          busy    = 1'b1;
          state_d = dmem_gnt_i ? WAIT : REQ;
        end
      end
      REQ: begin
        if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          req  = 1'b1;
          busy = 1'b1;
          if (dmem_gnt_i) state_d = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs are forced low during reset so nothing leaks onto the bus.
  assign dmem_req_o   = req & rstn_i;
  assign busy_o       = busy & rstn_i;
  assign dmem_we_o    = dmem_req_o & is_store;
  assign dmem_be_o    = dmem_req_o ? be_raw : 4'b0000;
  assign dmem_addr_o  = dmem_req_o ? {memM_addr_i[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata_o = (dmem_req_o & is_store) ? wdata_raw : '0;

  // ---------------------------------------------------------------- MEM/WB
  // Pass-through in IDLE without a started op; load result or store completion
  // on rvalid; otherwise (request in flight or timeout) a bubble.
  always_comb begin
    wb_valid = 1'b0;
    wb_data  = rdM_port_i.data;
    if ((state_q == IDLE) && !start) begin
      wb_valid = rdM_port_i.valid & ~stallM_i & ~misaligned;
    end else if (complete) begin
      wb_valid = rdM_port_i.valid & is_load;
      if (is_load) wb_data = load_data;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pcM_o         <= '0;
      instrM_o      <= '0;
      operationM_o  <= UNKNOWN;
      rdM_port_o    <= '0;
      misaligned_o  <= 1'b0;
      bus_timeout_o <= 1'b0;
    end else begin
      pcM_o            <= pcM_i;
      instrM_o         <= instrM_i;
      operationM_o     <= operationM_i;
      rdM_port_o.addr  <= rdM_port_i.addr;
      rdM_port_o.valid <= wb_valid;
      rdM_port_o.data  <= wb_data;
      misaligned_o     <= (state_q == IDLE) & misaligned;
      if (timeout_hit) bus_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import riscv_pkg::*;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             stallM_i;
  logic [XLEN-1:0]  pcM_i, instrM_i;
  operation_e       operationM_i;
  rd_port_t         rdM_port_i;
  logic             memM_wrt_ena_i;
  logic [XLEN-1:0]  memM_addr_i, memM_sdata_i;
  logic             dmem_req_o, dmem_we_o;
  logic [3:0]       dmem_be_o;
  logic [XLEN-1:0]  dmem_addr_o, dmem_wdata_o;
  logic             dmem_gnt_i, dmem_rvalid_i;
  logic [XLEN-1:0]  dmem_rdata_i;
  logic             busy_o;
  logic [XLEN-1:0]  pcM_o, instrM_o;
  operation_e       operationM_o;
  rd_port_t         rdM_port_o;
  logic             misaligned_o, bus_timeout_o;

  int checks = 0;
  int errors = 0;
  int n;

  mem_stage #(.MAX_WAIT(255)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .stallM_i(stallM_i),
    .pcM_i(pcM_i), .instrM_i(instrM_i), .operationM_i(operationM_i),
    .rdM_port_i(rdM_port_i), .memM_wrt_ena_i(memM_wrt_ena_i),
    .memM_addr_i(memM_addr_i), .memM_sdata_i(memM_sdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .busy_o(busy_o), .pcM_o(pcM_o), .instrM_o(instrM_o), .operationM_o(operationM_o),
    .rdM_port_o(rdM_port_o), .misaligned_o(misaligned_o), .bus_timeout_o(bus_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic rd_port_t mk_rd(input logic [4:0] a, input logic v, input logic [31:0] d);
    rd_port_t r;
    r.addr = a; r.valid = v; r.data = d;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    rstn_i = 1'b0; stallM_i = 1'b1; pcM_i = '0; instrM_i = '0;
    operationM_i = UNKNOWN; rdM_port_i = '0; memM_wrt_ena_i = 1'b0;
    memM_addr_i = '0; memM_sdata_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

    // Reset state
    #12;
    check("rst_rd", 64'(rdM_port_o), 64'(0));
    check("rst_op", 64'(operationM_o), 64'(UNKNOWN));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_req", 64'(dmem_req_o), 64'(0));
    check("rst_timeout", 64'(bus_timeout_o), 64'(0));
    check("rst_misaligned", 64'(misaligned_o), 64'(0));
    tick();
    rstn_i = 1'b1;

    // ADD pass-through, latency 1
    stallM_i = 1'b0; operationM_i = ADD; pcM_i = 32'h100; instrM_i = 32'h0020_81B3;
    rdM_port_i = mk_rd(5'd5, 1'b1, 32'h11);
    #1;
    check("add_busy", 64'(busy_o), 64'(0));
    check("add_req", 64'(dmem_req_o), 64'(0));
    tick();
    check("add_rd", 64'(rdM_port_o), 64'(mk_rd(5'd5, 1'b1, 32'h11)));
    check("add_pc", 64'(pcM_o), 64'(32'h100));
    check("add_op", 64'(operationM_o), 64'(ADD));

    // LB, gnt with req, rvalid next cycle
    operationM_i = LB; memM_addr_i = 32'h1003; rdM_port_i = mk_rd(5'd7, 1'b1, 32'h0);
    dmem_gnt_i = 1'b1;
    #1;
    check("lb_req", 64'(dmem_req_o), 64'(1));
    check("lb_be", 64'(dmem_be_o), 64'(4'b1000));
    check("lb_addr", 64'(dmem_addr_o), 64'(32'h1000));
    check("lb_we", 64'(dmem_we_o), 64'(0));
    check("lb_busy1", 64'(busy_o), 64'(1));
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_FFFF;
    #1;
    check("lb_bubble", 64'(rdM_port_o.valid), 64'(0));
    check("lb_busy2", 64'(busy_o), 64'(0));
    check("lb_req2", 64'(dmem_req_o), 64'(0));
    tick();
    dmem_rvalid_i = 1'b0;
    check("lb_rd", 64'(rdM_port_o), 64'(mk_rd(5'd7, 1'b1, 32'hFFFF_FF80)));

    // LHU, gnt delayed 3 cycles; rvalid alongside gnt in REQ must be ignored
    operationM_i = LHU; memM_addr_i = 32'h2002; rdM_port_i = mk_rd(5'd9, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      dmem_gnt_i    = (i == 3);
      dmem_rvalid_i = (i == 3);
      dmem_rdata_i  = (i == 3) ? 32'h1234_5678 : 32'h0;
      #1;
      check("lhu_req", 64'(dmem_req_o), 64'(1));
      check("lhu_addr", 64'(dmem_addr_o), 64'(32'h2000));
      check("lhu_be", 64'(dmem_be_o), 64'(4'b1100));
      tick();
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    #1;
    check("lhu_wait_busy", 64'(busy_o), 64'(1));
    check("lhu_wait_req", 64'(dmem_req_o), 64'(0));
    tick();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF_0000;
    tick();
    dmem_rvalid_i = 1'b0;
    check("lhu_rd", 64'(rdM_port_o), 64'(mk_rd(5'd9, 1'b1, 32'h0000_BEEF)));

    // SH store
    operationM_i = SH; memM_wrt_ena_i = 1'b1; memM_addr_i = 32'h3002;
    memM_sdata_i = 32'h1234_ABCD; rdM_port_i = mk_rd(5'd3, 1'b1, 32'h55);
    dmem_gnt_i = 1'b1;
    #1;
    check("sh_be", 64'(dmem_be_o), 64'(4'b1100));
    check("sh_wdata", 64'(dmem_wdata_o), 64'(32'hABCD_ABCD));
    check("sh_we", 64'(dmem_we_o), 64'(1));
    check("sh_addr", 64'(dmem_addr_o), 64'(32'h3000));
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1;
    tick();
    dmem_rvalid_i = 1'b0;
    check("sh_rd_valid", 64'(rdM_port_o.valid), 64'(0));

    // Misaligned LW, then bubbled SW
    operationM_i = LW; memM_wrt_ena_i = 1'b0; memM_addr_i = 32'h4001;
    rdM_port_i = mk_rd(5'd4, 1'b1, 32'h99);
    #1;
    check("mis_req", 64'(dmem_req_o), 64'(0));
    check("mis_busy", 64'(busy_o), 64'(0));
    tick();
    check("mis_pulse", 64'(misaligned_o), 64'(1));
    check("mis_rd_valid", 64'(rdM_port_o.valid), 64'(0));
    operationM_i = SW; memM_wrt_ena_i = 1'b1; stallM_i = 1'b1; memM_addr_i = 32'h4000;
    #1;
    check("stall_req", 64'(dmem_req_o), 64'(0));
    check("stall_busy", 64'(busy_o), 64'(0));
    tick();
    check("mis_pulse_end", 64'(misaligned_o), 64'(0));
    check("stall_rd_valid", 64'(rdM_port_o.valid), 64'(0));

    // Reset during WAIT, late rvalid afterwards ignored
    operationM_i = LW; memM_wrt_ena_i = 1'b0; stallM_i = 1'b0; memM_addr_i = 32'h5000;
    rdM_port_i = mk_rd(5'd10, 1'b1, 32'h0); dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    #1;
    check("wait_busy", 64'(busy_o), 64'(1));
    rstn_i = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'(0));
    check("arst_req", 64'(dmem_req_o), 64'(0));
    check("arst_rd", 64'(rdM_port_o), 64'(0));
    check("arst_op", 64'(operationM_o), 64'(UNKNOWN));
    check("arst_pc", 64'(pcM_o), 64'(0));
    operationM_i = ADD; rdM_port_i = mk_rd(5'd6, 1'b1, 32'h77);
    tick();
    rstn_i = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_0000;
    #1;
    check("stray_busy", 64'(busy_o), 64'(0));
    tick();
    dmem_rvalid_i = 1'b0;
    check("stray_rd", 64'(rdM_port_o), 64'(mk_rd(5'd6, 1'b1, 32'h77)));

    // Bus timeout: rvalid withheld
    operationM_i = LW; memM_addr_i = 32'h6000; rdM_port_i = mk_rd(5'd8, 1'b1, 32'h0);
    dmem_gnt_i = 1'b1;
    #1;
    n = 0;
    while (busy_o && n < 400) begin
      n++;
      tick();
      dmem_gnt_i = 1'b0;
    end
    check("to_busy_cycles", 64'(n), 64'(255));
    check("to_not_yet", 64'(bus_timeout_o), 64'(0));
    operationM_i = ADD; stallM_i = 1'b1;
    tick();
    check("to_flag", 64'(bus_timeout_o), 64'(1));
    check("to_rd_valid", 64'(rdM_port_o.valid), 64'(0));
    check("to_busy", 64'(busy_o), 64'(0));
    tick();
    check("to_sticky", 64'(bus_timeout_o), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
